stage_buffer_multi: RTL and testbench
=====================================

Name: stage_buffer_multi

Overview:
- Parametrised successor to the single FFT stage buffer.
- Holds NBUF frames of N complex words in a circular pool, so stage k can write frame i+1 while stage k+1 reads frame i.
- Two write ports and two read ports per cycle (butterfly pairs).
- Explicit start/done handshakes, registered read data, occupancy reporting, and a latched error code instead of a bare flag.

Parameters:
- N, 8: words per frame (power of 2)
- LOG_N, 3: log2(N)
- WIDTH, 32: word width (complex, re/im packed)
- NBUF, 2: number of frame buffers (power of 2, >=2)
- LOG_NBUF, 1: log2(NBUF)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- in_start  in  1  writer claims next empty buffer
- in_nd  in  1  write strobe for in_addr0/1, in_data0/1
- in_addr0  in  LOG_N  write address A
- in_addr1  in  LOG_N  write address B
- in_data0  in  WIDTH  write data A
- in_data1  in  WIDTH  write data B
- in_done  in  1  writer finished current frame
- in_ready  out  1  buffer at write pointer is EMPTY and no frame is being written
- out_start  in  1  reader claims oldest FULL buffer
- out_rd  in  1  read strobe for out_addr0/1
- out_addr0  in  LOG_N  read address A
- out_addr1  in  LOG_N  read address B
- out_data0  out  WIDTH  registered read data A
- out_data1  out  WIDTH  registered read data B
- out_valid  out  1  out_data0/1 valid (one cycle after out_rd)
- out_done  in  1  reader finished current frame
- out_avail  out  1  buffer at read pointer is FULL and no frame is being read
- occupancy  out  LOG_NBUF+1  count of non-EMPTY buffers
- error  out  1  sticky error flag
- error_code  out  3  first error cause, latched

Behaviour:
- Per-buffer state: EMPTY(0), WRITING(1), FULL(2), READING(3).
- Pointers: wp (write) and rp (read), LOG_NBUF bits, wrap modulo NBUF.
- Reset (rst=1 at clk edge):
  - all buffers EMPTY; wp=rp=0
  - out_valid=0, out_data0/1=0, error=0, error_code=0
  - in_ready=1, out_avail=0, occupancy=0
  - RAM contents not cleared
  - reset mid-frame aborts both frames with no error.
- in_ready and out_avail are registered-state decodes (combinational from current state), not next-state.
- in_start with in_ready=1:
  - buf[wp] goes EMPTY->WRITING on the next cycle.
  - in_nd is legal from the following cycle.
- in_nd while writing: RAM[wp][in_addr0]<=in_data0 and RAM[wp][in_addr1]<=in_data1 in the same cycle; if the addresses are equal, in_data1 wins.
- in_done while writing: buf[wp] WRITING->FULL, wp<=wp+1. An in_nd in the same cycle as in_done is still written.
- out_start with out_avail=1: buf[rp] FULL->READING.
- out_rd while reading: out_data0/1 <= RAM[rp][out_addr0/1]; out_valid=1 exactly one cycle later. Otherwise out_valid=0 and out_data holds.
- out_done while reading: buf[rp] READING->EMPTY, rp<=rp+1. An out_rd in the same cycle still produces data next cycle.
- Write and read sides are independent. in_done and out_done in the same cycle both take effect.
- A buffer freed by out_done is visible through in_ready in the next cycle.
- Same-cycle start+done on one side: done is processed, start is ignored, error 5 is raised.
- All pool buffers non-EMPTY: in_ready=0, occupancy=NBUF. A start request raises error 1 and no state changes.
- Error codes (illegal request ignored, no state change):
  - 1: in_start while !in_ready
  - 2: in_nd or in_done while not writing
  - 3: out_start while !out_avail
  - 4: out_rd or out_done while not reading
  - 5: start and done on the same side in one cycle
- error sets with the first error. error_code keeps the first cause until rst. If several errors occur in the same cycle, the lowest code is latched.
- occupancy updates one cycle after the causing event.

Optional Feature:
- Macro STAGE_BUFFER_COLLISION_EN.
- Defined: in_nd with in_addr0==in_addr1 raises error code 6. The write still occurs with in_data1 winning.
- Undefined: no check; code 6 is never produced.

Test Plan:
- Reset, then one frame (N=8), NBUF=2: in_start; in_nd x4 writing pairs (0,4),(1,5),(2,6),(3,7) with data 0x10+addr; in_done; out_start; out_rd addr (0,4) -> after in_done occupancy=1 and out_avail=1; out_data0=0x10, out_data1=0x14 one cycle after out_rd with out_valid=1; after out_done occupancy=0.
- Ping-pong: write frame A to buf0, then write frame B to buf1 while reading buf0 -> data streams stay uncorrupted; wp and rp wrap to 0 after the second done.
- Pool full, NBUF=2: two frames written, none read -> in_ready=0, occupancy=2. A third in_start gives error=1, error_code=1, and no state change.
- Illegal read: out_rd right after reset -> error_code=4. A subsequent in_start (code 1 would not apply) leaves error_code at 4.
- Same-cycle in_start+in_done while writing -> frame becomes FULL, no new buffer claimed, error_code=5.
- Reset asserted mid-read -> next cycle out_valid=0, occupancy=0, in_ready=1, error=0.

Source files
------------

// File: rtl/stage_buffer_multi_if.sv
// Writer/reader handshake bundle for stage_buffer_multi: master drives requests, slave returns data and status.
// Two write and two read lanes per cycle carry butterfly pairs.
interface stage_buffer_multi_if #(
  parameter int LOG_N    = 3,
  parameter int WIDTH    = 32,
  parameter int LOG_NBUF = 1
);
  logic                in_start;
  logic                in_nd;
  logic [LOG_N-1:0]    in_addr0;
  logic [LOG_N-1:0]    in_addr1;
  logic [WIDTH-1:0]    in_data0;
  logic [WIDTH-1:0]    in_data1;
  logic                in_done;
  logic                in_ready;
  logic                out_start;
  logic                out_rd;
  logic [LOG_N-1:0]    out_addr0;
  logic [LOG_N-1:0]    out_addr1;
  logic [WIDTH-1:0]    out_data0;
  logic [WIDTH-1:0]    out_data1;
  logic                out_valid;
  logic                out_done;
  logic                out_avail;
  logic [LOG_NBUF:0]   occupancy;
  logic                error;
  logic [2:0]          error_code;

  modport master (
    output in_start, in_nd, in_addr0, in_addr1, in_data0, in_data1, in_done,
    output out_start, out_rd, out_addr0, out_addr1, out_done,
    input  in_ready, out_data0, out_data1, out_valid, out_avail, occupancy, error, error_code
  );

  modport slave (
    input  in_start, in_nd, in_addr0, in_addr1, in_data0, in_data1, in_done,
    input  out_start, out_rd, out_addr0, out_addr1, out_done,
    output in_ready, out_data0, out_data1, out_valid, out_avail, occupancy, error, error_code
  );
endinterface

// File: rtl/stage_buffer_multi.sv
// Circular pool of NBUF frame buffers between FFT stages; 2 write + 2 read ports, read data registered (1 cycle).
// Illegal requests are dropped and latch an error code; STAGE_BUFFER_COLLISION_EN adds code 6 on equal write addresses.
module stage_buffer_multi #(
  parameter int N        = 8,
  parameter int LOG_N    = 3,
  parameter int WIDTH    = 32,
  parameter int NBUF     = 2,
  parameter int LOG_NBUF = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  stage_buffer_multi_if.slave   bus
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    WRITING = 2'd1,
    FULL    = 2'd2,
    READING = 2'd3
  } buf_state_t;

  buf_state_t            st [NBUF];
  logic [LOG_NBUF-1:0]   wp;
  logic [LOG_NBUF-1:0]   rp;
  logic [WIDTH-1:0]      ram [NBUF*N];

  logic                  writing;
  logic                  reading;
  logic                  wr_start;
  logic                  wr_nd;
  logic                  wr_done;
  logic                  rd_start;
  logic                  rd_ok;
  logic                  rd_done;
  logic [6:1]            err_vec;
  logic [2:0]            err_code_c;
  logic [LOG_NBUF:0]     occ_c;

  // Buffers are claimed and released strictly in pointer order, so the
  // pointed-to buffer alone tells whether a side may start.
  assign writing       = (st[wp] == WRITING);
  assign reading       = (st[rp] == READING);
  assign bus.in_ready  = (st[wp] == EMPTY);
  assign bus.out_avail = (st[rp] == FULL);
  assign bus.occupancy = occ_c;

  assign wr_start = bus.in_start && !bus.in_done && bus.in_ready;
  assign wr_nd    = bus.in_nd && writing;
  assign wr_done  = bus.in_done && writing;
  assign rd_start = bus.out_start && !bus.out_done && bus.out_avail;
  assign rd_ok    = bus.out_rd && reading;
  assign rd_done  = bus.out_done && reading;

  always_comb begin
    err_vec    = '0;
    err_vec[1] = bus.in_start && !bus.in_done && !bus.in_ready;
    err_vec[2] = (bus.in_nd || bus.in_done) && !writing;
    err_vec[3] = bus.out_start && !bus.out_done && !bus.out_avail;
    err_vec[4] = (bus.out_rd || bus.out_done) && !reading;
    err_vec[5] = (bus.in_start && bus.in_done) || (bus.out_start && bus.out_done);
`ifdef STAGE_BUFFER_COLLISION_EN
    err_vec[6] = bus.in_nd && (bus.in_addr0 == bus.in_addr1);
`else
    err_vec[6] = 1'b0;
`endif
    // Descending scan so the lowest active code is the one left standing.
    err_code_c = 3'd0;
    for (int i = 6; i >= 1; i--) begin
      if (err_vec[i]) err_code_c = 3'(i);
    end
  end

  always_comb begin
    occ_c = '0;
    for (int i = 0; i < NBUF; i++) begin
      if (st[i] != EMPTY) occ_c = occ_c + (LOG_NBUF+1)'(1);
    end
  end

  // Frame storage is never cleared; port B is written last so it wins on equal addresses.
  always_ff @(posedge clk) begin
    if (wr_nd) begin
      ram[{wp, bus.in_addr0}] <= bus.in_data0;
      ram[{wp, bus.in_addr1}] <= bus.in_data1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NBUF; i++) st[i] <= EMPTY;
      wp             <= '0;
      rp             <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_data0  <= '0;
      bus.out_data1  <= '0;
      bus.error      <= 1'b0;
      bus.error_code <= 3'd0;
    end else begin
      if (wr_start) st[wp] <= WRITING;
      if (wr_done) begin
        st[wp] <= FULL;
        wp     <= wp + LOG_NBUF'(1);
      end
      if (rd_start) st[rp] <= READING;
      if (rd_done) begin
        st[rp] <= EMPTY;
        rp     <= rp + LOG_NBUF'(1);
      end
      bus.out_valid <= rd_ok;
      if (rd_ok) begin
        bus.out_data0 <= ram[{rp, bus.out_addr0}];
        bus.out_data1 <= ram[{rp, bus.out_addr1}];
      end
      if (!bus.error && (|err_vec)) begin
        bus.error      <= 1'b1;
        bus.error_code <= err_code_c;
      end
    end
  end

endmodule

// File: tb/tb_stage_buffer_multi.sv
// Bench for stage_buffer_multi: directed scenarios plus random traffic, checked against a frame-queue model.
module tb_stage_buffer_multi;
  localparam int N        = 8;
  localparam int LOG_N    = 3;
  localparam int WIDTH    = 32;
  localparam int NBUF     = 2;
  localparam int LOG_NBUF = 1;

  typedef logic [N-1:0][WIDTH-1:0] frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stage_buffer_multi_if #(.LOG_N(LOG_N), .WIDTH(WIDTH), .LOG_NBUF(LOG_NBUF)) bus ();

  stage_buffer_multi #(
    .N(N), .LOG_N(LOG_N), .WIDTH(WIDTH), .NBUF(NBUF), .LOG_NBUF(LOG_NBUF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Model: the pool as a FIFO of completed frames plus the frames currently open on each side.
  frame_t     fq[$];
  logic [N-1:0] mq[$];
  frame_t     wcur, rcur;
  logic [N-1:0] wmask, rmask;
  bit         m_wr, m_rd, m_valid, m_err, k0, k1;
  logic [WIDTH-1:0] m_d0, m_d1;
  int         m_code;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_occ();
    return fq.size() + int'(m_wr) + int'(m_rd);
  endfunction

  function automatic bit m_rdy();
    return !m_wr && (m_occ() < NBUF);
  endfunction

  function automatic bit m_avl();
    return !m_rd && (fq.size() > 0);
  endfunction

  task automatic model_step();
    bit rdy, avl;
    int code;
    if (rst) begin
      fq.delete(); mq.delete();
      m_wr = 0; m_rd = 0; m_valid = 0; m_err = 0; m_code = 0;
      m_d0 = '0; m_d1 = '0; k0 = 1; k1 = 1;
      return;
    end
    rdy = m_rdy();
    avl = m_avl();
    code = 0;
`ifdef STAGE_BUFFER_COLLISION_EN
    if (bus.in_nd && bus.in_addr0 == bus.in_addr1) code = 6;
`endif
    if ((bus.in_start && bus.in_done) || (bus.out_start && bus.out_done)) code = 5;
    if ((bus.out_rd || bus.out_done) && !m_rd) code = 4;
    if (bus.out_start && !bus.out_done && !avl) code = 3;
    if ((bus.in_nd || bus.in_done) && !m_wr) code = 2;
    if (bus.in_start && !bus.in_done && !rdy) code = 1;
    if (!m_err && code != 0) begin
      m_err = 1;
      m_code = code;
    end
    if (bus.out_rd && m_rd) begin
      m_valid = 1;
      m_d0 = rcur[bus.out_addr0]; k0 = rmask[bus.out_addr0];
      m_d1 = rcur[bus.out_addr1]; k1 = rmask[bus.out_addr1];
    end else begin
      m_valid = 0;
    end
    if (bus.in_nd && m_wr) begin
      wcur[bus.in_addr0] = bus.in_data0; wmask[bus.in_addr0] = 1'b1;
      wcur[bus.in_addr1] = bus.in_data1; wmask[bus.in_addr1] = 1'b1;
    end
    if (bus.in_done && m_wr) begin
      fq.push_back(wcur); mq.push_back(wmask);
      m_wr = 0;
    end
    if (bus.out_done && m_rd) m_rd = 0;
    if (bus.in_start && !bus.in_done && rdy) begin
      m_wr = 1; wmask = '0;
    end
    if (bus.out_start && !bus.out_done && avl) begin
      rcur = fq.pop_front(); rmask = mq.pop_front();
      m_rd = 1;
    end
  endtask

  task automatic check_all();
    chk("in_ready",   32'(bus.in_ready),   32'(m_rdy()));
    chk("out_avail",  32'(bus.out_avail),  32'(m_avl()));
    chk("occupancy",  32'(bus.occupancy),  32'(m_occ()));
    chk("out_valid",  32'(bus.out_valid),  32'(m_valid));
    chk("error",      32'(bus.error),      32'(m_err));
    chk("error_code", 32'(bus.error_code), 32'(m_code));
    if (k0) chk("out_data0", bus.out_data0, m_d0);
    if (k1) chk("out_data1", bus.out_data1, m_d1);
  endtask

  task automatic clear_inputs();
    bus.in_start = 0; bus.in_nd = 0; bus.in_done = 0;
    bus.out_start = 0; bus.out_rd = 0; bus.out_done = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    clear_inputs();
    rst = 0;
  endtask

  task automatic set_wr(input int a0, input int a1, input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1);
    bus.in_nd = 1;
    bus.in_addr0 = LOG_N'(a0); bus.in_addr1 = LOG_N'(a1);
    bus.in_data0 = d0; bus.in_data1 = d1;
  endtask

  task automatic set_rd(input int a0, input int a1);
    bus.out_rd = 1;
    bus.out_addr0 = LOG_N'(a0); bus.out_addr1 = LOG_N'(a1);
  endtask

  task automatic write_frame(input logic [WIDTH-1:0] base);
    bus.in_start = 1; tick();
    for (int i = 0; i < N/2; i++) begin
      set_wr(i, i + N/2, base + WIDTH'(i), base + WIDTH'(i + N/2));
      tick();
    end
    bus.in_done = 1; tick();
  endtask

  task automatic do_reset();
    rst = 1; tick();
  endtask

  initial begin
    clear_inputs();
    bus.in_addr0 = '0; bus.in_addr1 = '0; bus.in_data0 = '0; bus.in_data1 = '0;
    bus.out_addr0 = '0; bus.out_addr1 = '0;
    do_reset();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_occ", 32'(bus.occupancy), 32'd0);
    chk("rst_avail", 32'(bus.out_avail), 32'd0);

    // Single frame through the pool.
    write_frame(32'h10);
    chk("f1_occ", 32'(bus.occupancy), 32'd1);
    chk("f1_avail", 32'(bus.out_avail), 32'd1);
    bus.out_start = 1; tick();
    set_rd(0, 4); tick();
    chk("f1_valid", 32'(bus.out_valid), 32'd1);
    chk("f1_d0", bus.out_data0, 32'h10);
    chk("f1_d1", bus.out_data1, 32'h14);
    bus.out_done = 1; tick();
    chk("f1_occ_end", 32'(bus.occupancy), 32'd0);

    // Ping-pong: write B while reading A.
    do_reset();
    write_frame(32'h200);
    bus.in_start = 1; bus.out_start = 1; tick();
    for (int i = 0; i < N/2; i++) begin
      set_wr(i, i + N/2, 32'h300 + i, 32'h300 + i + N/2);
      set_rd(i, i + N/2);
      tick();
      chk("pp_a0", bus.out_data0, 32'h200 + i);
      chk("pp_a1", bus.out_data1, 32'h200 + i + N/2);
    end
    bus.in_done = 1; bus.out_done = 1; tick();
    bus.out_start = 1; tick();
    set_rd(3, 6); tick();
    chk("pp_b0", bus.out_data0, 32'h303);
    chk("pp_b1", bus.out_data1, 32'h306);
    bus.out_done = 1; tick();
    write_frame(32'h340);
    chk("pp_wrap_avail", 32'(bus.out_avail), 32'd1);

    // Pool full.
    do_reset();
    write_frame(32'h400);
    write_frame(32'h500);
    chk("full_ready", 32'(bus.in_ready), 32'd0);
    chk("full_occ", 32'(bus.occupancy), 32'd2);
    bus.in_start = 1; tick();
    chk("full_err", 32'(bus.error), 32'd1);
    chk("full_code", 32'(bus.error_code), 32'd1);
    chk("full_occ2", 32'(bus.occupancy), 32'd2);

    // Illegal read keeps the first cause.
    do_reset();
    set_rd(1, 2); tick();
    chk("ill_code", 32'(bus.error_code), 32'd4);
    bus.in_start = 1; tick();
    chk("ill_code2", 32'(bus.error_code), 32'd4);

    // Start together with done on the write side.
    do_reset();
    bus.in_start = 1; tick();
    set_wr(0, 1, 32'hA0, 32'hA1); tick();
    bus.in_start = 1; bus.in_done = 1; tick();
    chk("sd_code", 32'(bus.error_code), 32'd5);
    chk("sd_occ", 32'(bus.occupancy), 32'd1);
    chk("sd_avail", 32'(bus.out_avail), 32'd1);

    // Reset in the middle of a read.
    do_reset();
    write_frame(32'h600);
    bus.out_start = 1; tick();
    set_rd(2, 5); tick();
    set_rd(1, 6); rst = 1; tick();
    chk("mr_valid", 32'(bus.out_valid), 32'd0);
    chk("mr_occ", 32'(bus.occupancy), 32'd0);
    chk("mr_ready", 32'(bus.in_ready), 32'd1);
    chk("mr_err", 32'(bus.error), 32'd0);

    // Random traffic with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      rst           = ($urandom_range(99) < 2);
      bus.in_start  = ($urandom_range(99) < 15);
      bus.in_done   = ($urandom_range(99) < 10);
      bus.out_start = ($urandom_range(99) < 15);
      bus.out_done  = ($urandom_range(99) < 8);
      if ($urandom_range(99) < 45)
        set_wr(int'($urandom_range(N-1)), int'($urandom_range(N-1)), $urandom, $urandom);
      if ($urandom_range(99) < 45)
        set_rd(int'($urandom_range(N-1)), int'($urandom_range(N-1)));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
